// File: rtl/dmem_lsu_if.sv
// dmem_lsu_if: bundles the pipeline-side request/response signals and the
// data-memory bus of the load/store unit.
//   master : environment side (memory stage drives req_*, memory drives
//            mem_rdata/mem_ack; receives stall, resp_*, misalign, timeout, mem_*)
//   slave  : load/store unit side (the reverse directions)
interface dmem_lsu_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
);
   localparam int unsigned BE_W = XLEN / 8;

   // pipeline side
   logic              req_valid;
   logic              req_we;
   logic [2:0]        req_dmtype;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_wdata;
   logic              stall;
   logic              resp_valid;
   logic [XLEN-1:0]   resp_rdata;
   logic              misalign;
   logic              timeout;

   // memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [BE_W-1:0]   mem_be;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_ack;

   modport master (
      output req_valid, req_we, req_dmtype, req_addr, req_wdata,
      output mem_rdata, mem_ack,
      input  stall, resp_valid, resp_rdata, misalign, timeout,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_dmtype, req_addr, req_wdata,
      input  mem_rdata, mem_ack,
      output stall, resp_valid, resp_rdata, misalign, timeout,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/dmem_lsu.sv
// dmem_lsu: single-outstanding load/store unit between the memory stage and
// data memory. Handles sub-word accesses with lane alignment, holds the
// pipeline through memory wait states, and reports misaligned/illegal
// accesses and missing acknowledges.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : dmem_lsu_if.slave (request/response + memory bus)
module dmem_lsu #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input logic        clk,
   input logic        reset,
   dmem_lsu_if.slave  bus
);
   localparam int unsigned BE_W  = XLEN / 8;
   localparam int unsigned OFS_W = $clog2(BE_W);
   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        dmtype_q, dmtype_d;
   logic [OFS_W-1:0]  ofs_q, ofs_d;

   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [BE_W-1:0]   mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic              misalign_q, misalign_d;
   logic              timeout_q, timeout_d;
   logic              stall_c;

   logic [OFS_W-1:0]  ofs_c;
   logic              ok_c;
   logic [7:0]        mask8_c;
   logic [XLEN-1:0]   load_c;

   // Truncate d to its low n bits, then sign- or zero-extend back to XLEN.
   function automatic logic [XLEN-1:0] ext_f(input logic [XLEN-1:0] d,
                                             input int unsigned     n,
                                             input logic            sgn);
      logic [XLEN-1:0] up;
      up = d << (XLEN - n);
      if (sgn) return XLEN'($signed(up) >>> (XLEN - n));
      return up >> (XLEN - n);
   endfunction

   assign ofs_c = bus.req_addr[OFS_W-1:0];

   // Alignment/legality check and size mask for the incoming request.
   always_comb begin
      ok_c    = 1'b0;
      mask8_c = 8'h00;
      case (bus.req_dmtype)
         3'b000: begin
            ok_c    = (ofs_c & OFS_W'(3)) == '0;
            mask8_c = 8'h0F;
         end
         3'b001, 3'b010: begin
            ok_c    = ~ofs_c[0];
            mask8_c = 8'h03;
         end
         3'b011, 3'b100: begin
            ok_c    = 1'b1;
            mask8_c = 8'h01;
         end
         3'b101: begin
            ok_c    = (XLEN == 64) && (ofs_c == '0);
            mask8_c = 8'hFF;
         end
         3'b110: begin
            ok_c    = (XLEN == 64) && ((ofs_c & OFS_W'(3)) == '0);
            mask8_c = 8'h0F;
         end
         default: begin
            ok_c    = 1'b0;
            mask8_c = 8'h00;
         end
      endcase
   end

   // Load data: move the addressed lane down to bit 0, then extend.
   always_comb begin
      logic [XLEN-1:0] sh;
      sh = bus.mem_rdata >> {ofs_q, 3'b000};
      case (dmtype_q)
         3'b000:  load_c = ext_f(sh, 32, 1'b1);
         3'b001:  load_c = ext_f(sh, 16, 1'b1);
         3'b010:  load_c = ext_f(sh, 16, 1'b0);
         3'b011:  load_c = ext_f(sh, 8, 1'b1);
         3'b100:  load_c = ext_f(sh, 8, 1'b0);
         3'b101:  load_c = sh;
         3'b110:  load_c = ext_f(sh, 32, 1'b0);
         default: load_c = '0;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dmtype_d     = dmtype_q;
      ofs_d        = ofs_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = '0;
      misalign_d   = 1'b0;
      timeout_d    = 1'b0;
      stall_c      = 1'b0;

      case (state_q)
         S_IDLE: begin
            stall_c = bus.req_valid;
            if (bus.req_valid) begin
               dmtype_d = bus.req_dmtype;
               ofs_d    = ofs_c;
               if (ok_c) begin
                  state_d     = S_WAIT;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_we;
                  mem_addr_d  = {bus.req_addr[ADDR_W-1:OFS_W], OFS_W'(0)};
                  mem_be_d    = BE_W'(mask8_c) << ofs_c;
                  mem_wdata_d = bus.req_wdata << {ofs_c, 3'b000};
               end else begin
                  state_d    = S_ERR;
                  misalign_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            // Ack wins over a timeout compare in the same cycle.
            if (bus.mem_ack) begin
               state_d      = S_DONE;
               resp_valid_d = 1'b1;
               resp_rdata_d = mem_we_q ? '0 : load_c;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
               state_d   = S_ERR;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
            if (bus.mem_ack || state_d == S_ERR) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_be_d    = '0;
               mem_wdata_d = '0;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         dmtype_q     <= '0;
         ofs_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= '0;
         mem_wdata_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         misalign_q   <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dmtype_q     <= dmtype_d;
         ofs_q        <= ofs_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         misalign_q   <= misalign_d;
         timeout_q    <= timeout_d;
      end
   end

   assign bus.stall      = stall_c;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.misalign   = misalign_q;
   assign bus.timeout    = timeout_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu (XLEN=32, TIMEOUT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 unit later, so each sample shows the registered state of that cycle.
module tb_dmem_lsu;
   logic clk;
   logic reset;
   int   pass_cnt;
   int   total_cnt;

   dmem_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

   dmem_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_dmtype = 3'b000;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.mem_rdata  = '0;
      bus.mem_ack    = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      #1;
      total_cnt++; if (bus.mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); else pass_cnt++;
      total_cnt++; if (bus.resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); else pass_cnt++;
      total_cnt++; if ({bus.misalign, bus.timeout} !== 2'b00) $display("FAIL rst_err: got %b want 00", {bus.misalign, bus.timeout}); else pass_cnt++;
      total_cnt++; if (bus.mem_be !== 4'h0 || bus.mem_addr !== 32'h0) $display("FAIL rst_bus: got be=%h addr=%h want 0", bus.mem_be, bus.mem_addr); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", bus.stall); else pass_cnt++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_word_load();
      // cycle 0: accept
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = 3'b000; bus.req_addr = 32'h100;
      #1;
      total_cnt++; if (bus.stall !== 1'b1 || bus.mem_req !== 1'b0) $display("FAIL wl_c0: got stall=%b req=%b want 1 0", bus.stall, bus.mem_req); else pass_cnt++;
      // cycle 1: request out, ack with data
      tick();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'hF || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) $display("FAIL wl_c1: got req=%b be=%h addr=%h we=%b want 1 f 100 0", bus.mem_req, bus.mem_be, bus.mem_addr, bus.mem_we); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL wl_c1_stall: got stall=%b rv=%b want 1 0", bus.stall, bus.resp_valid); else pass_cnt++;
      // cycle 2: response, request still asserted but ignored
      tick();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF) $display("FAIL wl_resp: got rv=%b data=%h want 1 deadbeef", bus.resp_valid, bus.resp_rdata); else pass_cnt++;
      total_cnt++; if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL wl_c2: got stall=%b req=%b want 0 0", bus.stall, bus.mem_req); else pass_cnt++;
      bus.req_valid = 1'b0;
      tick();
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL wl_c3: got rv=%b req=%b want 0 0", bus.resp_valid, bus.mem_req); else pass_cnt++;
   endtask

   task automatic test_subword_load();
      logic [2:0]  dt [5] = '{3'b011, 3'b100, 3'b001, 3'b010, 3'b011};
      logic [31:0] ad [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
      logic [3:0]  be [5] = '{4'h8, 4'h8, 4'hC, 4'h3, 4'h2};
      logic [31:0] ex [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00002233, 32'h00000022};
      for (int i = 0; i < 5; i++) begin
         bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = dt[i]; bus.req_addr = ad[i];
         tick();
         bus.mem_ack = 1'b1; bus.mem_rdata = 32'h80112233;
         #1;
         total_cnt++; if (bus.mem_be !== be[i] || bus.mem_addr !== 32'h100) $display("FAIL sub_be[%0d]: got be=%h addr=%h want %h 100", i, bus.mem_be, bus.mem_addr, be[i]); else pass_cnt++;
         tick();
         bus.mem_ack = 1'b0;
         #1;
         total_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== ex[i]) $display("FAIL sub_data[%0d]: got rv=%b data=%h want 1 %h", i, bus.resp_valid, bus.resp_rdata, ex[i]); else pass_cnt++;
         bus.req_valid = 1'b0;
         tick();
      end
   endtask

   task automatic test_half_store();
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_dmtype = 3'b001;
      bus.req_addr = 32'h202; bus.req_wdata = 32'h0000ABCD;
      bus.mem_rdata = 32'hFFFFFFFF;
      for (int c = 1; c <= 4; c++) begin
         tick();
         if (c == 4) bus.mem_ack = 1'b1;
         #1;
         total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hABCD0000 || bus.mem_be !== 4'hC || bus.mem_addr !== 32'h200) $display("FAIL hs_wait[%0d]: got req=%b we=%b wd=%h be=%h addr=%h want 1 1 abcd0000 c 200", c, bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_be, bus.mem_addr); else pass_cnt++;
         total_cnt++; if (bus.resp_valid !== 1'b0 || bus.stall !== 1'b1) $display("FAIL hs_stall[%0d]: got rv=%b stall=%b want 0 1", c, bus.resp_valid, bus.stall); else pass_cnt++;
      end
      tick();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) $display("FAIL hs_resp: got rv=%b data=%h want 1 0", bus.resp_valid, bus.resp_rdata); else pass_cnt++;
      bus.req_valid = 1'b0; bus.req_we = 1'b0;
      tick();
   endtask

   task automatic test_misalign();
      logic [2:0]  dt [3] = '{3'b000, 3'b101, 3'b110};
      logic [31:0] ad [3] = '{32'h102, 32'h100, 32'h100};
      for (int i = 0; i < 3; i++) begin
         bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = dt[i]; bus.req_addr = ad[i];
         #1;
         total_cnt++; if (bus.stall !== 1'b1) $display("FAIL mis_c0[%0d]: got stall=%b want 1", i, bus.stall); else pass_cnt++;
         tick();
         bus.mem_ack = 1'b1;
         #1;
         total_cnt++; if (bus.misalign !== 1'b1 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.resp_valid !== 1'b0) $display("FAIL mis_c1[%0d]: got mis=%b req=%b stall=%b rv=%b want 1 0 0 0", i, bus.misalign, bus.mem_req, bus.stall, bus.resp_valid); else pass_cnt++;
         bus.req_valid = 1'b0;
         tick();
         bus.mem_ack = 1'b0;
         #1;
         total_cnt++; if (bus.misalign !== 1'b0 || bus.resp_valid !== 1'b0) $display("FAIL mis_c2[%0d]: got mis=%b rv=%b want 0 0", i, bus.misalign, bus.resp_valid); else pass_cnt++;
      end
   endtask

   task automatic test_timeout();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = 3'b000; bus.req_addr = 32'h300;
      for (int c = 1; c <= 5; c++) begin
         tick();
         #1;
         total_cnt++; if (bus.mem_req !== 1'b1 || bus.timeout !== 1'b0) $display("FAIL to_wait[%0d]: got req=%b to=%b want 1 0", c, bus.mem_req, bus.timeout); else pass_cnt++;
      end
      tick();
      #1;
      total_cnt++; if (bus.timeout !== 1'b1 || bus.mem_req !== 1'b0 || bus.stall !== 1'b0 || bus.resp_valid !== 1'b0) $display("FAIL to_pulse: got to=%b req=%b stall=%b rv=%b want 1 0 0 0", bus.timeout, bus.mem_req, bus.stall, bus.resp_valid); else pass_cnt++;
      // cycle 7: new request accepted normally
      tick();
      bus.req_addr = 32'h104;
      #1;
      total_cnt++; if (bus.timeout !== 1'b0 || bus.stall !== 1'b1) $display("FAIL to_next_c0: got to=%b stall=%b want 0 1", bus.timeout, bus.stall); else pass_cnt++;
      tick();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104) $display("FAIL to_next_req: got req=%b addr=%h want 1 104", bus.mem_req, bus.mem_addr); else pass_cnt++;
      tick();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0BADF00D) $display("FAIL to_next_resp: got rv=%b data=%h want 1 0badf00d", bus.resp_valid, bus.resp_rdata); else pass_cnt++;
      bus.req_valid = 1'b0;
      tick();
   endtask

   task automatic test_ack_priority();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = 3'b000; bus.req_addr = 32'h400;
      for (int c = 1; c <= 5; c++) begin
         tick();
         if (c == 5) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678;
         end
      end
      tick();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b1 || bus.timeout !== 1'b0 || bus.resp_rdata !== 32'h12345678) $display("FAIL ackprio: got rv=%b to=%b data=%h want 1 0 12345678", bus.resp_valid, bus.timeout, bus.resp_rdata); else pass_cnt++;
      bus.req_valid = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = 3'b000; bus.req_addr = 32'h500;
      tick();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEBABE;
      tick();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b1 || bus.stall !== 1'b0) $display("FAIL b2b_done: got rv=%b stall=%b want 1 0", bus.resp_valid, bus.stall); else pass_cnt++;
      // next cycle: new byte store presented immediately
      tick();
      bus.req_we = 1'b1; bus.req_dmtype = 3'b100; bus.req_addr = 32'h501; bus.req_wdata = 32'h0000005A;
      #1;
      total_cnt++; if (bus.stall !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL b2b_accept: got stall=%b rv=%b req=%b want 1 0 0", bus.stall, bus.resp_valid, bus.mem_req); else pass_cnt++;
      tick();
      bus.mem_ack = 1'b1;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_be !== 4'h2 || bus.mem_wdata !== 32'h00005A00 || bus.mem_addr !== 32'h500) $display("FAIL b2b_store: got req=%b we=%b be=%h wd=%h addr=%h want 1 1 2 00005a00 500", bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata, bus.mem_addr); else pass_cnt++;
      tick();
      bus.mem_ack = 1'b0;
      #1;
      total_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) $display("FAIL b2b_resp: got rv=%b data=%h want 1 0", bus.resp_valid, bus.resp_rdata); else pass_cnt++;
      bus.req_valid = 1'b0; bus.req_we = 1'b0;
      tick();
   endtask

   task automatic test_reset_in_wait();
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_dmtype = 3'b000; bus.req_addr = 32'h600;
      tick();
      tick();
      #1;
      total_cnt++; if (bus.mem_req !== 1'b1) $display("FAIL rw_wait: got req=%b want 1", bus.mem_req); else pass_cnt++;
      reset = 1'b1; bus.req_valid = 1'b0;
      tick();
      reset = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
      #1;
      total_cnt++; if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0) $display("FAIL rw_drop: got req=%b stall=%b want 0 0", bus.mem_req, bus.stall); else pass_cnt++;
      for (int c = 0; c < 2; c++) begin
         tick();
         bus.mem_ack = 1'b0;
         #1;
         total_cnt++; if (bus.resp_valid !== 1'b0 || bus.misalign !== 1'b0 || bus.timeout !== 1'b0 || bus.mem_req !== 1'b0) $display("FAIL rw_quiet[%0d]: got rv=%b mis=%b to=%b req=%b want 0 0 0 0", c, bus.resp_valid, bus.misalign, bus.timeout, bus.mem_req); else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_word_load();
      test_subword_load();
      test_half_store();
      test_misalign();
      test_timeout();
      test_ack_priority();
      test_back_to_back();
      test_reset_in_wait();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised load/store unit between the CPU's memory stage and data memory. It replaces the direct `Addr_out`/`Data_out`/`mem_w` connection of the single-cycle core, and adds four things: sub-word accesses, lane alignment, a stall handshake for memory with wait states, and misalignment and timeout reporting. One access is in flight at a time, and the pipeline is held via `stall` until it completes.

## Interface
Parameters:
- `XLEN`, default 32: data width; legal values 32 or 64. `BE_W = XLEN/8`, `OFS_W = log2(BE_W)`.
- `ADDR_W`, default 32: byte-address width.
- `TIMEOUT`, default 255: maximum wait cycles for `mem_ack`; 0 disables the timeout.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: memory-stage access present.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_dmtype`  in  3: access type.
  - 000 word
  - 001 half signed
  - 010 half unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101 doubleword (legal only when XLEN=64)
  - 110 word unsigned (XLEN=64 only)
  - 111 illegal
- `req_addr`  in  ADDR_W: byte address (ALU result).
- `req_wdata`  in  XLEN: store data, low-aligned (rs2).
- `stall`  out  1: hold the pipeline.
- `resp_valid`  out  1: one-cycle completion pulse.
- `resp_rdata`  out  XLEN: extended load data; 0 for stores.
- `misalign`  out  1: one-cycle pulse on a misaligned or illegal access.
- `timeout`  out  1: one-cycle pulse when `mem_ack` does not arrive in time.
- `mem_req`  out  1: memory request.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: `req_addr` with its low OFS_W bits cleared.
- `mem_be`  out  BE_W: byte enables.
- `mem_wdata`  out  XLEN: lane-shifted store data.
- `mem_rdata`  in  XLEN: read data, valid when `mem_ack`=1.
- `mem_ack`  in  1: memory completion.

## Operation
States: IDLE, WAIT, DONE, ERR.

- **IDLE**
  - When `req_valid`=1, the request is latched.
  - Alignment check against `ofs = req_addr[OFS_W-1:0]`:
    - half requires `ofs[0]`=0.
    - word requires `ofs[1:0]`=0.
    - doubleword requires `ofs[2:0]`=0.
    - An illegal `dmtype` for the configured XLEN counts as misaligned.
  - If the check passes, go to WAIT.
  - If it fails, go to ERR with cause = misalign. No memory access is made.
- **WAIT**
  - `mem_req`=1. `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` are registered and held stable until ack.
  - Byte enables: `mem_be` = size mask (1, 3, 0xF or 0xFF) << `ofs`.
  - Write data: `mem_wdata` = `req_wdata` << (8·`ofs`).
  - On `mem_ack`=1:
    - Loads capture `(mem_rdata >> 8·ofs)`, truncate to the access size, then sign- or zero-extend according to `dmtype`.
    - Go to DONE.
  - Wait counter: cleared on entry to WAIT, increments each cycle without ack. If `TIMEOUT`≠0 and the counter equals `TIMEOUT`, go to ERR with cause = timeout and drop `mem_req`.
- **DONE**
  - `resp_valid`=1 and `resp_rdata` is valid. Go to IDLE.
  - `req_valid` is ignored in this cycle; it still belongs to the completing instruction.
- **ERR**
  - Pulse `misalign` or `timeout` according to the cause. `resp_valid`=0. Go to IDLE.

Stall rule: `stall` = (state==IDLE & `req_valid`) | (state==WAIT). It is combinational and low in DONE and ERR.

## Timing
- Reset values: state=IDLE; all outputs 0, except `stall`, which follows its combinational equation.
- Reset during WAIT:
  - `mem_req` drops at the next edge.
  - The in-flight access is abandoned and no `resp_valid` is issued.
  - A later `mem_ack` is ignored.
- Request latency with zero wait states:
  - Accept in cycle 0.
  - `mem_req` in cycle 1, with `mem_ack` sampled in cycle 1.
  - `resp_valid` in cycle 2.
  - `stall` is high in cycles 0–1.
- With N wait states, `resp_valid` arrives in cycle 2+N.
- Misaligned access: accept in cycle 0, `misalign` in cycle 1, `stall` high in cycle 0 only.
- Timeout: with no ack, `timeout` pulses in cycle `TIMEOUT`+2. `mem_req` is low in that cycle.
- `mem_ack` outside WAIT is ignored. `mem_ack` arriving in the same cycle as the timeout compare takes priority, and the access completes normally.
- At most one request is outstanding. A new request can be accepted in the cycle after DONE or ERR.

## Test plan
- Word load, XLEN=32, addr 0x100, memory returns 0xDEADBEEF with ack in cycle 1 → `mem_be`=0xF, `resp_valid` in cycle 2, `resp_rdata`=0xDEADBEEF, `stall` high for exactly 2 cycles.
- Byte-signed load at addr 0x103 with `mem_rdata`=0x80112233 → `mem_be`=0x8, `resp_rdata`=0xFFFFFF80. The same access with byte unsigned → 0x00000080.
- Half store at addr 0x202 with `req_wdata`=0x0000ABCD, ack delayed 3 cycles → `mem_wdata`=0xABCD0000 and `mem_be`=0xC, both held stable for all 4 WAIT cycles; `resp_valid` in cycle 5 with `resp_rdata`=0.
- Word load at addr 0x102 → no `mem_req`, `misalign` pulse in cycle 1, no `resp_valid`. Dmtype 101 with XLEN=32 → `misalign`.
- TIMEOUT=4, no ack → `timeout` pulse in cycle 6, `mem_req` low in that cycle. The next request is accepted normally.
- Assert `reset` in the second WAIT cycle, then ack one cycle later → `mem_req`=0 after the reset edge, the ack is ignored, and no `resp_valid`, `misalign` or `timeout` is produced.
